// File: rtl/aq_axis_pkg.sv
// Shared sizing helpers and default geometry for the AXI4-Stream width down-converter.
package aq_axis_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  localparam int DEF_OUT_W = 32;
  localparam int DEF_RATIO = 2;
  localparam int IN_W      = DEF_OUT_W * DEF_RATIO;
  localparam int IN_B      = IN_W / 8;
  localparam int OUT_B     = DEF_OUT_W / 8;
  localparam int LANE_W    = clog2(DEF_RATIO);

endpackage

// File: rtl/aq_axis_lane_sel.sv
// Priority encoder over the pending-lane mask: picks the next lane to emit
// and reports whether any / exactly one lane is still pending.
module aq_axis_lane_sel #(
  parameter int RATIO     = 2,
  parameter int LANE_BITS = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic [RATIO-1:0]     mask,
  output logic [LANE_BITS-1:0] lane,
  output logic                 any_pending,
  output logic                 one_pending
);

  always_comb begin
    lane        = '0;
    any_pending = |mask;
    one_pending = any_pending && ((mask & (mask - RATIO'(1))) == '0);
    // Last assignment wins, so the scan runs away from the preferred end.
    if (MSB_FIRST) begin
      for (int i = 0; i < RATIO; i++)
        if (mask[i]) lane = LANE_BITS'(i);
    end else begin
      for (int i = RATIO - 1; i >= 0; i--)
        if (mask[i]) lane = LANE_BITS'(i);
    end
  end

endmodule

// File: rtl/aq_axis_dwidth_down.sv
// AXI4-Stream width down-converter: one wide beat is held and split into
// narrow sub-words, skipping null lanes, with a registered output stage.
module aq_axis_dwidth_down
  import aq_axis_pkg::*;
#(
  parameter int OUT_W     = DEF_OUT_W,
  parameter int RATIO     = DEF_RATIO,
  parameter bit SKIP_NULL = 1'b1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                         ARESETN,
  input  logic                         I_AXIS_TCLK,
  input  logic [OUT_W*RATIO-1:0]       I_AXIS_TDATA,
  input  logic                         I_AXIS_TVALID,
  output logic                         I_AXIS_TREADY,
  input  logic [OUT_W*RATIO/8-1:0]     I_AXIS_TSTRB,
  input  logic [OUT_W*RATIO/8-1:0]     I_AXIS_TKEEP,
  input  logic                         I_AXIS_TLAST,
  output logic                         O_AXIS_TCLK,
  output logic [OUT_W-1:0]             O_AXIS_TDATA,
  output logic                         O_AXIS_TVALID,
  input  logic                         O_AXIS_TREADY,
  output logic [OUT_W/8-1:0]           O_AXIS_TSTRB,
  output logic [OUT_W/8-1:0]           O_AXIS_TKEEP,
  output logic                         O_AXIS_TLAST
);

  localparam int IN_WIDTH  = OUT_W * RATIO;
  localparam int IN_BYTES  = IN_WIDTH / 8;
  localparam int OUT_BYTES = OUT_W / 8;
  localparam int LANE_BITS = clog2(RATIO);

  if (OUT_W % 8 != 0) begin : g_chk_out_w
    $error("aq_axis_dwidth_down: OUT_W must be a multiple of 8");
  end
  if (RATIO < 2) begin : g_chk_ratio
    $error("aq_axis_dwidth_down: RATIO must be at least 2");
  end

  logic [IN_WIDTH-1:0]  hold_data;
  logic [IN_BYTES-1:0]  hold_strb;
  logic [IN_BYTES-1:0]  hold_keep;
  logic                 hold_last;
  logic [RATIO-1:0]     hold_mask;

  logic [RATIO-1:0]     keep_mask;
  logic [RATIO-1:0]     in_mask;
  logic                 in_null;
  logic [LANE_BITS-1:0] next_lane;
  logic                 any_pending;
  logic                 one_pending;
  logic                 out_free;
  logic                 take_in;
  logic                 emit;

  aq_axis_lane_sel #(
    .RATIO     (RATIO),
    .LANE_BITS (LANE_BITS),
    .MSB_FIRST (MSB_FIRST)
  ) u_lane_sel (
    .mask        (hold_mask),
    .lane        (next_lane),
    .any_pending (any_pending),
    .one_pending (one_pending)
  );

  // A null last beat still has to deliver its TLAST, so it keeps one lane.
  always_comb begin
    keep_mask = '0;
    for (int i = 0; i < RATIO; i++)
      keep_mask[i] = |I_AXIS_TKEEP[i*OUT_BYTES +: OUT_BYTES];
    in_null = (keep_mask == '0);
    if (!SKIP_NULL)
      in_mask = '1;
    else if (in_null && I_AXIS_TLAST)
      in_mask = MSB_FIRST ? (RATIO'(1) << (RATIO - 1)) : RATIO'(1);
    else
      in_mask = keep_mask;
  end

  assign out_free      = !O_AXIS_TVALID || O_AXIS_TREADY;
  assign emit          = any_pending && out_free;
  assign I_AXIS_TREADY = ARESETN && (!any_pending || (one_pending && out_free));
  assign take_in       = I_AXIS_TVALID && I_AXIS_TREADY;
  assign O_AXIS_TCLK   = I_AXIS_TCLK;

  always_ff @(posedge I_AXIS_TCLK or negedge ARESETN) begin
    if (!ARESETN) begin
      hold_data     <= '0;
      hold_strb     <= '0;
      hold_keep     <= '0;
      hold_last     <= 1'b0;
      hold_mask     <= '0;
      O_AXIS_TDATA  <= '0;
      O_AXIS_TSTRB  <= '0;
      O_AXIS_TKEEP  <= '0;
      O_AXIS_TLAST  <= 1'b0;
      O_AXIS_TVALID <= 1'b0;
    end else begin
      if (emit) begin
        O_AXIS_TDATA  <= hold_data[int'(next_lane)*OUT_W +: OUT_W];
        O_AXIS_TSTRB  <= hold_strb[int'(next_lane)*OUT_BYTES +: OUT_BYTES];
        O_AXIS_TKEEP  <= hold_keep[int'(next_lane)*OUT_BYTES +: OUT_BYTES];
        O_AXIS_TLAST  <= hold_last && one_pending;
        O_AXIS_TVALID <= 1'b1;
      end else if (O_AXIS_TREADY) begin
        O_AXIS_TVALID <= 1'b0;
      end

      // A new beat is only accepted as the final pending lane leaves,
      // so its mask simply replaces the one being retired.
      if (take_in) begin
        hold_data <= I_AXIS_TDATA;
        hold_strb <= (SKIP_NULL && in_null) ? '0 : I_AXIS_TSTRB;
        hold_keep <= I_AXIS_TKEEP;
        hold_last <= I_AXIS_TLAST;
        hold_mask <= in_mask;
      end else if (emit) begin
        hold_mask[next_lane] <= 1'b0;
      end
    end
  end

endmodule
